// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O responder: register map,
// STATUS bit positions, CONTROL bits and the LFSR feedback step.
package io_pkg;

  localparam logic [2:0] IO_STATUS  = 3'd0;
  localparam logic [2:0] IO_PLAYER1 = 3'd1;
  localparam logic [2:0] IO_PLAYER2 = 3'd2;
  localparam logic [2:0] IO_PLAYER3 = 3'd3;
  localparam logic [2:0] IO_PLAYER4 = 3'd4;
  localparam logic [2:0] IO_RANDOM  = 3'd5;
  localparam logic [2:0] IO_CONTROL = 3'd6;
  localparam logic [2:0] IO_TIMER   = 3'd7;

  localparam logic [15:0] IO_WINDOW = 16'd8;

  localparam int ST_FLAG      = 0;
  localparam int ST_FIRST_LSB = 1;
  localparam int ST_OVERFLOW  = 3;

  localparam int CTL_CLEAR = 0;
  localparam int CTL_ARM   = 1;

  // Galois right-shift form of x^16+x^14+x^13+x^11: exponent e maps to bit e-1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchroniser, stability counter and a one-cycle
// pulse when the debounced level goes from 0 to 1.
module btn_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]  sync;
  logic [15:0] count;

  // The level only moves after the synced input has disagreed with it for DEB_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        count <= '0;
      end else if (count == DEB_CYCLES - 16'd1) begin
        count <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/io_responder.sv
// CPU-side responder for the I/O window: status/player/random/control/timer
// registers plus debounced, arbitrated controller press events.
module io_responder
  import io_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'd43,
  parameter logic [15:0] DEB_CYCLES = 16'd1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] btn,
  output logic [15:0] readdata,
  output logic        rdvalid,
  output logic        inputFlag,
  output logic [15:0] randomVal
);

  logic [15:0] offset_full;
  logic [2:0]  offset;
  logic        sel;
  logic        rd_req;
  logic        wr_req;

  assign offset_full = adr - IO_BASE;
  assign offset      = offset_full[2:0];
  assign sel         = (adr >= IO_BASE) && (offset_full < IO_WINDOW);
  assign rd_req      = sel && memread && !memwrite;
  assign wr_req      = sel && memwrite;

  logic [15:0] level;
  logic [15:0] rise;

  for (genvar i = 0; i < 16; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  logic [3:0][3:0] level_nib;
  logic [3:0][3:0] rise_nib;
  logic [3:0]      player_rise;
  logic [1:0]      first_idx;
  logic            press;

  assign level_nib = level;
  assign rise_nib  = rise;

  // Lowest player index wins when several players rise in the same cycle.
  always_comb begin
    first_idx = 2'd0;
    for (int p = 0; p < 4; p++) begin
      player_rise[p] = |rise_nib[p];
    end
    for (int p = 3; p >= 0; p--) begin
      if (player_rise[p]) begin
        first_idx = 2'(p);
      end
    end
  end

  logic            armed;
  logic            flag;
  logic            ovf;
  logic [1:0]      first;
  logic [3:0][3:0] players;
  logic [15:0]     timer;
  logic [15:0]     lfsr;

  assign press = armed && (|player_rise);

  logic            armed_n;
  logic            flag_n;
  logic            ovf_n;
  logic [1:0]      first_n;
  logic [3:0][3:0] players_n;

  // Clears (read or CONTROL) are applied before a same-cycle press, so the press is never lost.
  always_comb begin
    armed_n   = armed;
    flag_n    = flag;
    ovf_n     = ovf;
    first_n   = first;
    players_n = players;
    if (rd_req && offset == IO_STATUS) begin
      flag_n = 1'b0;
      ovf_n  = 1'b0;
    end
    if (wr_req && offset == IO_CONTROL) begin
      armed_n = writedata[CTL_ARM];
      if (writedata[CTL_CLEAR]) begin
        flag_n    = 1'b0;
        ovf_n     = 1'b0;
        players_n = '0;
      end
    end
    if (press) begin
      if (!flag_n) begin
        flag_n               = 1'b1;
        first_n              = first_idx;
        players_n[first_idx] = level_nib[first_idx];
      end else begin
        ovf_n = 1'b1;
      end
    end
  end

  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (offset)
      IO_STATUS: begin
        rd_mux[ST_FLAG]              = flag;
        rd_mux[ST_FIRST_LSB +: 2]    = first;
        rd_mux[ST_OVERFLOW]          = ovf;
      end
      IO_PLAYER1: rd_mux = {12'd0, players[0]};
      IO_PLAYER2: rd_mux = {12'd0, players[1]};
      IO_PLAYER3: rd_mux = {12'd0, players[2]};
      IO_PLAYER4: rd_mux = {12'd0, players[3]};
      IO_RANDOM:  rd_mux = lfsr;
      IO_TIMER:   rd_mux = timer;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b0;
      flag     <= 1'b0;
      ovf      <= 1'b0;
      first    <= 2'd0;
      players  <= '0;
      timer    <= '0;
      lfsr     <= LFSR_SEED;
      readdata <= '0;
      rdvalid  <= 1'b0;
    end else begin
      armed   <= armed_n;
      flag    <= flag_n;
      ovf     <= ovf_n;
      first   <= first_n;
      players <= players_n;
      timer   <= (wr_req && offset == IO_TIMER) ? writedata : timer + 16'd1;
      lfsr    <= lfsr_next(lfsr);
      rdvalid <= rd_req;
      if (rd_req) begin
        readdata <= rd_mux;
      end
    end
  end

  assign inputFlag = flag;
  assign randomVal = lfsr;

endmodule
